// File: rtl/dec_echo_scheduler.sv
// Echo scheduler: buffers UART rx bytes, drives the decimal converter,
// then streams the resulting ASCII digits (plus separator) to the UART tx.
module dec_echo_scheduler #(
  parameter int unsigned FIFO_DEPTH     = 4,
  parameter bit          SEND_SEP       = 1'b1,
  parameter logic [7:0]  SEP_CHAR       = 8'h20,
  parameter bit          SUPPRESS_ZEROS = 1'b0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [7:0]  rx_data,
  input  logic        rx_done,
  output logic [7:0]  conv_char,
  output logic        conv_go,
  input  logic [23:0] conv_ascii,
  output logic [7:0]  tx_data,
  output logic        tx_start,
  input  logic        tx_busy,
  output logic        overflow,
  output logic        idle
);

  localparam int unsigned AW =
    (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam logic [AW:0] DEPTH_C =
    (AW+1)'(FIFO_DEPTH);
  localparam logic [1:0]  LAST_IDX =
    SEND_SEP ? 2'd3 : 2'd2;
  localparam logic [7:0]  ZERO_C = 8'h30;

  typedef enum logic [2:0] {
    S_IDLE,
    S_CONV,
    S_LOAD,
    S_SEND,
    S_TXW,
    S_TXD
  } state_e;

  state_e        state_q, state_d;
  logic [7:0]    mem_q [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [AW:0]   cnt_q, cnt_d;
  logic [23:0]   dig_q, dig_d;
  logic [1:0]    idx_q, idx_d;
  logic [7:0]    conv_char_q, conv_char_d;
  logic          conv_go_q, conv_go_d;
  logic [7:0]    tx_data_q, tx_data_d;
  logic          tx_start_q, tx_start_d;
  logic          ovf_q, ovf_d;
  logic          idle_q, idle_d;

  logic       full;
  logic       empty;
  logic       push;
  logic       pop;
  logic [1:0] first_idx;

  function automatic logic [7:0] char_at(
    input logic [23:0] d,
    input logic [1:0]  i
  );
    logic [7:0] c;
    unique case (i)
      2'd0:    c = d[23:16];
      2'd1:    c = d[15:8];
      2'd2:    c = d[7:0];
      default: c = SEP_CHAR;
    endcase
    return c;
  endfunction

  // Fullness uses the pre-pop count: a same-cycle pop never makes room.
  assign full  = (cnt_q == DEPTH_C);
  assign empty = (cnt_q == '0);
  assign push  = rx_done && !full;
  assign pop   = (state_q == S_IDLE) && !empty;

  always_comb begin
    first_idx = 2'd0;
    if (SUPPRESS_ZEROS) begin
      if (conv_ascii[23:16] == ZERO_C) begin
        first_idx = 2'd1;
        if (conv_ascii[15:8] == ZERO_C) begin
          first_idx = 2'd2;
        end
      end
    end
  end

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (push) begin
      wr_ptr_d = wr_ptr_q + AW'(1);
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + AW'(1);
    end
    cnt_d = cnt_q
          + (AW+1)'(push)
          - (AW+1)'(pop);
    ovf_d = rx_done && full;
  end

  always_comb begin
    state_d     = state_q;
    dig_d       = dig_q;
    idx_d       = idx_q;
    conv_char_d = conv_char_q;
    conv_go_d   = 1'b0;
    tx_data_d   = tx_data_q;
    tx_start_d  = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (!empty) begin
          conv_char_d = mem_q[rd_ptr_q];
          conv_go_d   = 1'b1;
          state_d     = S_CONV;
        end
      end
      S_CONV: begin
        state_d = S_LOAD;
      end
      S_LOAD: begin
        dig_d = conv_ascii;
        idx_d = first_idx;
        // Fire the first char straight away when tx is free.
        if (!tx_busy) begin
          tx_data_d  = char_at(conv_ascii, first_idx);
          tx_start_d = 1'b1;
          state_d    = S_TXW;
        end else begin
          state_d = S_SEND;
        end
      end
      S_SEND: begin
        if (!tx_busy) begin
          tx_data_d  = char_at(dig_q, idx_q);
          tx_start_d = 1'b1;
          state_d    = S_TXW;
        end
      end
      S_TXW: begin
        if (tx_busy) begin
          state_d = S_TXD;
        end
      end
      S_TXD: begin
        if (!tx_busy) begin
          if (idx_q == LAST_IDX) begin
            state_d = S_IDLE;
          end else begin
            idx_d   = idx_q + 2'd1;
            state_d = S_SEND;
          end
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
    idle_d = (state_d == S_IDLE) && (cnt_d == '0);
  end

  always_ff @(posedge clk) begin
    if (push) begin
      mem_q[wr_ptr_q] <= rx_data;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      cnt_q       <= '0;
      dig_q       <= '0;
      idx_q       <= '0;
      conv_char_q <= '0;
      conv_go_q   <= 1'b0;
      tx_data_q   <= '0;
      tx_start_q  <= 1'b0;
      ovf_q       <= 1'b0;
      idle_q      <= 1'b1;
    end else begin
      state_q     <= state_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      cnt_q       <= cnt_d;
      dig_q       <= dig_d;
      idx_q       <= idx_d;
      conv_char_q <= conv_char_d;
      conv_go_q   <= conv_go_d;
      tx_data_q   <= tx_data_d;
      tx_start_q  <= tx_start_d;
      ovf_q       <= ovf_d;
      idle_q      <= idle_d;
    end
  end

  assign conv_char = conv_char_q;
  assign conv_go   = conv_go_q;
  assign tx_data   = tx_data_q;
  assign tx_start  = tx_start_q;
  assign overflow  = ovf_q;
  assign idle      = idle_q;

endmodule

// File: tb/tb_dec_echo_scheduler.sv
// Directed bench: two scheduler instances (zeros kept / suppressed)
// with behavioural converter and transmitter models.
module tb_dec_echo_scheduler;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [7:0]  rxd    [2] = '{8'h0, 8'h0};
  logic        rxv    [2] = '{1'b0, 1'b0};
  logic [7:0]  cchar  [2];
  logic        cgo    [2];
  logic [23:0] cascii [2] = '{24'h0, 24'h0};
  logic [7:0]  txd    [2];
  logic        txs    [2];
  logic        txb    [2] = '{1'b0, 1'b0};
  logic        ovf    [2];
  logic        idl    [2];

  int blen   [2] = '{2, 2};
  bit hold   [2] = '{1'b0, 1'b0};
  int bcnt   [2] = '{0, 0};
  int ngo    [2] = '{0, 0};
  int nstart [2] = '{0, 0};
  int novf   [2] = '{0, 0};
  logic [7:0] txq0 [$];
  logic [7:0] txq1 [$];

  int n_chk = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  dec_echo_scheduler #(
    .FIFO_DEPTH(4), .SEND_SEP(1'b1),
    .SEP_CHAR(8'h20), .SUPPRESS_ZEROS(1'b0)
  ) u_a (
    .clk(clk), .rst(rst),
    .rx_data(rxd[0]), .rx_done(rxv[0]),
    .conv_char(cchar[0]), .conv_go(cgo[0]),
    .conv_ascii(cascii[0]),
    .tx_data(txd[0]), .tx_start(txs[0]),
    .tx_busy(txb[0]),
    .overflow(ovf[0]), .idle(idl[0])
  );

  dec_echo_scheduler #(
    .FIFO_DEPTH(4), .SEND_SEP(1'b1),
    .SEP_CHAR(8'h20), .SUPPRESS_ZEROS(1'b1)
  ) u_b (
    .clk(clk), .rst(rst),
    .rx_data(rxd[1]), .rx_done(rxv[1]),
    .conv_char(cchar[1]), .conv_go(cgo[1]),
    .conv_ascii(cascii[1]),
    .tx_data(txd[1]), .tx_start(txs[1]),
    .tx_busy(txb[1]),
    .overflow(ovf[1]), .idle(idl[1])
  );

  function automatic logic [23:0] to_ascii(input logic [7:0] v);
    return {8'h30 + v / 8'd100,
            8'h30 + (v / 8'd10) % 8'd10,
            8'h30 + v % 8'd10};
  endfunction

  always @(posedge clk) begin
    for (int i = 0; i < 2; i++) begin
      if (cgo[i]) begin
        cascii[i] <= to_ascii(cchar[i]);
        ngo[i]    <= ngo[i] + 1;
      end
      if (ovf[i]) novf[i] <= novf[i] + 1;
      if (txs[i]) begin
        nstart[i] <= nstart[i] + 1;
        if (i == 0) txq0.push_back(txd[i]);
        else        txq1.push_back(txd[i]);
        txb[i]  <= 1'b1;
        bcnt[i] <= blen[i];
      end else if (txb[i] && !hold[i]) begin
        if (bcnt[i] == 0) txb[i] <= 1'b0;
        else bcnt[i] <= bcnt[i] - 1;
      end
    end
  end

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic int qsize(input int i);
    return (i == 0) ? txq0.size() : txq1.size();
  endfunction

  function automatic logic [7:0] qch(input int i, input int k);
    if (i == 0) return (k < txq0.size()) ? txq0[k] : 8'hxx;
    return (k < txq1.size()) ? txq1[k] : 8'hxx;
  endfunction

  task automatic rx(input int i, input logic [7:0] v);
    rxd[i] = v;
    rxv[i] = 1'b1;
    step();
    rxv[i] = 1'b0;
  endtask

  task automatic wait_done(input int i, input int base,
                           input int n, input int lim);
    int c = 0;
    while (!(qsize(i) >= base + n && idl[i]) && c < lim) begin
      step();
      c++;
    end
    check("done_timeout", 32'(qsize(i) >= base + n && idl[i]), 1);
  endtask

  task automatic wait_starts(input int i, input int tgt,
                             input int lim);
    int c = 0;
    while (nstart[i] < tgt && c < lim) begin
      step();
      c++;
    end
    check("start_timeout", 32'(nstart[i] >= tgt), 1);
  endtask

  task automatic check_str(input int i, input int base,
                           input string tag, input string s);
    check({tag, "_len"}, 32'(qsize(i) - base), 32'(s.len()));
    for (int k = 0; k < s.len(); k++) begin
      check($sformatf("%s_ch%0d", tag, k),
            {24'h0, qch(i, base + k)}, {24'h0, s[k]});
    end
  endtask

  initial begin
    int base;
    int s0;
    int g0;
    int o0;
    int vals [4] = '{0, 7, 40, 255};
    string exps [4] = '{"0 ", "7 ", "40 ", "255 "};

    repeat (3) step();
    for (int i = 0; i < 2; i++) begin
      check("rst_idle", 32'(idl[i]), 1);
      check("rst_txs", 32'(txs[i]), 0);
      check("rst_go", 32'(cgo[i]), 0);
      check("rst_ovf", 32'(ovf[i]), 0);
      check("rst_txd", 32'(txd[i]), 0);
    end
    rst = 1'b0;
    step();

    base = qsize(0);
    s0 = nstart[0];
    g0 = ngo[0];
    rx(0, 8'd123);
    step();
    check("lat_go", 32'(cgo[0]), 1);
    check("lat_cchar", 32'(cchar[0]), 123);
    step();
    check("lat_go_off", 32'(cgo[0]), 0);
    step();
    check("lat_txs", 32'(txs[0]), 1);
    check("lat_txd", 32'(txd[0]), 32'h31);
    wait_done(0, base, 4, 300);
    check_str(0, base, "t1", "123 ");
    check("t1_starts", 32'(nstart[0] - s0), 4);
    check("t1_gos", 32'(ngo[0] - g0), 1);

    for (int k = 0; k < 4; k++) begin
      base = qsize(1);
      rx(1, 8'(vals[k]));
      wait_done(1, base, exps[k].len(), 300);
      check_str(1, base, $sformatf("t2_%0d", vals[k]), exps[k]);
    end

    blen[1] = 20;
    base = qsize(1);
    o0 = novf[1];
    for (int k = 0; k < 6; k++) begin
      rxd[1] = 8'(10 + k);
      rxv[1] = 1'b1;
      step();
      if (k == 4) check("t3_full", 32'(u_b.cnt_q), 4);
      if (k == 5) check("t3_ovf", 32'(ovf[1]), 1);
    end
    rxv[1] = 1'b0;
    step();
    check("t3_ovf_off", 32'(ovf[1]), 0);
    wait_done(1, base, 15, 3000);
    check_str(1, base, "t3", "10 11 12 13 14 ");
    check("t3_novf", 32'(novf[1] - o0), 1);
    blen[1] = 2;

    base = qsize(0);
    s0 = nstart[0];
    rx(0, 8'd200);
    wait_starts(0, s0 + 1, 100);
    hold[0] = 1'b1;
    rx(0, 8'd7);
    rx(0, 8'd8);
    repeat (30) step();
    check("t4_starts", 32'(nstart[0] - s0), 1);
    check("t4_busy", 32'(txb[0]), 1);
    check("t4_cnt", 32'(u_a.cnt_q), 2);
    check("t4_state", 32'(u_a.state_q), 5);
    check("t4_idle", 32'(idl[0]), 0);
    hold[0] = 1'b0;
    wait_done(0, base, 12, 600);
    check_str(0, base, "t4", "200 007 008 ");

    s0 = nstart[0];
    rx(0, 8'd123);
    wait_starts(0, s0 + 2, 200);
    rst = 1'b1;
    step();
    rst = 1'b0;
    check("t5_txs", 32'(txs[0]), 0);
    check("t5_idle", 32'(idl[0]), 1);
    check("t5_cnt", 32'(u_a.cnt_q), 0);
    base = qsize(0);
    rx(0, 8'd5);
    wait_done(0, base, 4, 300);
    check_str(0, base, "t5", "005 ");

    base = qsize(1);
    rx(1, 8'd3);
    rx(1, 8'd9);
    check("t6_cnt", 32'(u_b.cnt_q), 1);
    check("t6_go", 32'(cgo[1]), 1);
    check("t6_cchar", 32'(cchar[1]), 3);
    wait_done(1, base, 4, 400);
    check_str(1, base, "t6", "3 9 ");

    $display("Simulation finished: %0d checks, %0d errors",
             n_chk, n_err);
    $finish;
  end

endmodule
